// File: rtl/ysyx_22050710_wb_arb.sv
// GPR write-port arbiter: WB writes vs. a small FIFO of MDU results, with an optional
// starvation counter built when YSYX_22050710_WB_ARB_STARVE_EN is defined.
module ysyx_22050710_wb_arb #(
    parameter int GPR_ADDR_WD    = 5,
    parameter int GPR_WD         = 64,
    parameter int MDU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_ws_valid,
    input  logic                          i_ws_gpr_wen,
    input  logic [GPR_ADDR_WD-1:0]        i_ws_gpr_waddr,
    input  logic [GPR_WD-1:0]             i_ws_gpr_wdata,
    output logic                          o_ws_ready,
    input  logic                          i_mdu_valid,
    input  logic [GPR_ADDR_WD-1:0]        i_mdu_waddr,
    input  logic [GPR_WD-1:0]             i_mdu_wdata,
    output logic                          o_mdu_ready,
    output logic                          o_rf_wen,
    output logic [GPR_ADDR_WD-1:0]        o_rf_waddr,
    output logic [GPR_WD-1:0]             o_rf_wdata,
    output logic                          o_mdu_grant,
    output logic [(2**GPR_ADDR_WD)-1:0]   o_mdu_pend_mask
);

    localparam int PTR_W = $clog2(MDU_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [GPR_ADDR_WD-1:0] fifo_addr [MDU_FIFO_DEPTH];
    logic [GPR_WD-1:0]      fifo_data [MDU_FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       offset;
    logic [CNT_W-1:0]       count;

    logic empty;
    logic full;
    logic ws_req;
    logic mdu_req;
    logic push;
    logic pop;
    logic starved;
    logic grant_mdu;
    logic grant_ws;
    logic head_wen;
    logic [GPR_ADDR_WD-1:0] head_addr;
    logic [GPR_WD-1:0]      head_data;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(MDU_FIFO_DEPTH));
    assign ws_req    = i_ws_valid & i_ws_gpr_wen & (i_ws_gpr_waddr != '0);
    assign mdu_req   = ~empty;
    assign head_addr = fifo_addr[rd_ptr];
    assign head_data = fifo_data[rd_ptr];
    assign head_wen  = (head_addr != '0);

    assign o_mdu_ready = ~full;
    assign push        = i_mdu_valid & ~full;
    assign pop         = grant_mdu;

`ifdef YSYX_22050710_WB_ARB_STARVE_EN
    logic [3:0] starve_cnt;

    assign starved = mdu_req & (starve_cnt == 4'(STARVE_LIMIT));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            starve_cnt <= '0;
        end else if (grant_mdu || empty) begin
            starve_cnt <= '0;
        end else if (grant_ws && (starve_cnt != 4'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    // Without the counter the limit has no effect; keep it referenced.
    localparam int unused_starve_limit = STARVE_LIMIT;
    assign starved = 1'b0;
`endif

    always_comb begin
        grant_mdu = 1'b0;
        grant_ws  = 1'b0;
        if (full || starved) begin
            grant_mdu = 1'b1;
        end else if (ws_req) begin
            grant_ws = 1'b1;
        end else if (mdu_req) begin
            grant_mdu = 1'b1;
        end
    end

    // An x0 head is popped without touching the register file.
    always_comb begin
        o_rf_wen   = 1'b0;
        o_rf_waddr = '0;
        o_rf_wdata = '0;
        if (grant_ws) begin
            o_rf_wen   = 1'b1;
            o_rf_waddr = i_ws_gpr_waddr;
            o_rf_wdata = i_ws_gpr_wdata;
        end else if (grant_mdu && head_wen) begin
            o_rf_wen   = 1'b1;
            o_rf_waddr = head_addr;
            o_rf_wdata = head_data;
        end
    end

    assign o_mdu_grant = grant_mdu;
    assign o_ws_ready  = i_ws_valid & ~(grant_mdu & ws_req);

    always_comb begin
        o_mdu_pend_mask = '0;
        offset          = '0;
        for (int i = 0; i < MDU_FIFO_DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr;
            if ((CNT_W'(offset) < count) && (fifo_addr[i] != '0)) begin
                o_mdu_pend_mask[fifo_addr[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= i_mdu_waddr;
            fifo_data[wr_ptr] <= i_mdu_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
